// File: rtl/act_if.sv
// Bundle of controller-facing signals for act_ctrl: the requester side drives en/req*,
// the controller side returns acks, activation selects, status and a debug state view.
interface act_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             req1;
  logic             req2;
  logic             ack1;
  logic             ack2;
  logic [1:0]       sel_i;
  logic             sel_o1;
  logic             sel_o2;
  logic             busy;
  logic [CNT_W-1:0] xfer_cnt;
  logic [1:0]       state;

  // Handshake: a reqN held high is a request; it is only sampled while the controller is
  // idle and enabled. Once granted the transfer always runs to completion, and ackN pulses
  // for exactly one cycle on the final drive cycle. A req still high after its ack is
  // treated as a fresh request.
  modport master (
    input  en, req1, req2,
    output ack1, ack2, sel_i, sel_o1, sel_o2, busy, xfer_cnt, state
  );

  modport slave (
    output en, req1, req2,
    input  ack1, ack2, sel_i, sel_o1, sel_o2, busy, xfer_cnt, state
  );
endinterface

// File: rtl/act_ctrl.sv
// Activation transfer controller: round-robin arbiter between two ports that moves the
// activation value act1->act2 (req1) or act2->act1 (req2) through a CAP/DRV/GAP sequence.
module act_ctrl #(
  parameter int DRV_CYC = 1,
  parameter int CNT_W   = 16
) (
  input  logic  clk,
  input  logic  rst,
  act_if.master bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CAP  = 2'b01;
  localparam logic [1:0] DRV  = 2'b10;
  localparam logic [1:0] GAP  = 2'b11;
  localparam logic [3:0] LAST = 4'(DRV_CYC - 1);

  logic [1:0]       r_state;
  logic             r_dir;      // 1: port-1 transfer (act1 -> act2), 0: port-2 transfer
  logic             r_last_p2;  // last grant went to port 2
  logic [3:0]       r_cnt;
  logic             r_ack1;
  logic             r_ack2;
  logic [1:0]       r_sel_i;
  logic             r_sel_o1;
  logic             r_sel_o2;
  logic             r_busy;
  logic [CNT_W-1:0] r_xfer;

  logic [1:0] w_nstate;
  logic       w_ndir;
  logic [3:0] w_ncnt;
  logic       w_grant;
  logic       w_grant1;
  logic       w_ack;

  always_comb begin
    w_nstate = r_state;
    w_ndir   = r_dir;
    w_ncnt   = r_cnt;
    w_grant  = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      IDLE: begin
        w_ncnt = 4'd0;
        if (bus.en && (bus.req1 || bus.req2)) begin
          w_grant  = 1'b1;
          w_grant1 = bus.req1 && (!bus.req2 || r_last_p2);
          w_ndir   = w_grant1;
          w_nstate = CAP;
        end
      end
      CAP: begin
        w_ncnt   = 4'd0;
        w_nstate = DRV;
      end
      DRV: begin
        if (r_cnt == LAST) w_nstate = GAP;
        else               w_ncnt   = r_cnt + 4'd1;
      end
      GAP:     w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  assign w_ack = (w_nstate == DRV) && (w_ncnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_dir     <= 1'b0;
      r_last_p2 <= 1'b1;
      r_cnt     <= 4'd0;
      r_ack1    <= 1'b0;
      r_ack2    <= 1'b0;
      r_sel_i   <= 2'b00;
      r_sel_o1  <= 1'b0;
      r_sel_o2  <= 1'b0;
      r_busy    <= 1'b0;
      r_xfer    <= '0;
    end else begin
      r_state  <= w_nstate;
      r_dir    <= w_ndir;
      r_cnt    <= w_ncnt;
      if (w_grant) r_last_p2 <= !w_grant1;
      r_ack1   <= w_ack && w_ndir;
      r_ack2   <= w_ack && !w_ndir;
      r_sel_o1 <= (w_nstate == DRV) && !w_ndir;
      r_sel_o2 <= (w_nstate == DRV) && w_ndir;
      r_busy   <= (w_nstate != IDLE);
      if (w_ack) r_xfer <= r_xfer + 1'b1;
      // CAP selects the source port; DRV selects the destination so its value recirculates.
      case (w_nstate)
        CAP:     r_sel_i <= {1'b1, !w_ndir};
        DRV:     r_sel_i <= {1'b1, w_ndir};
        default: r_sel_i <= 2'b00;
      endcase
    end
  end

  assign bus.ack1     = r_ack1;
  assign bus.ack2     = r_ack2;
  assign bus.sel_i    = r_sel_i;
  assign bus.sel_o1   = r_sel_o1;
  assign bus.sel_o2   = r_sel_o2;
  assign bus.busy     = r_busy;
  assign bus.xfer_cnt = r_xfer;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_act_ctrl.sv
// Directed bench for act_ctrl: a vector table on a DRV_CYC=1/CNT_W=4 instance plus
// hand-written sequences for arbitration, enable gating, reset abort, DRV_CYC=3 and wrap.
module tb_act_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  act_if #(.CNT_W(4))  ia ();
  act_if #(.CNT_W(16)) ib ();

  act_ctrl #(.DRV_CYC(1), .CNT_W(4))  dut_a (.clk(clk), .rst(rst), .bus(ia));
  act_ctrl #(.DRV_CYC(3), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  typedef struct {
    logic       en, r1, r2;
    logic       a1, a2;
    logic [1:0] si;
    logic       o1, o2, bsy;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[21];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ia.en = 1'b0; ia.req1 = 1'b0; ia.req2 = 1'b0;
    ib.en = 1'b0; ib.req1 = 1'b0; ib.req2 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if ((ia.sel_o1 && ia.sel_o2) || (ib.sel_o1 && ib.sel_o2) ||
          ia.sel_i == 2'b01 || ib.sel_i == 2'b01) begin
        n_err++;
        $display("FAIL sel_excl: a sel_o=%b%b sel_i=%b b sel_o=%b%b sel_i=%b",
                 ia.sel_o1, ia.sel_o2, ia.sel_i, ib.sel_o1, ib.sel_o2, ib.sel_i);
      end
    end
  end

  initial begin
    int acks;
    int busy_cyc;

    //            en r1 r2  a1 a2 si     o1 o2 bsy cnt
    tbl[0]  = '{1, 1, 0,  0, 0, 2'b10, 0, 0, 1, 4'd0};
    tbl[1]  = '{1, 1, 0,  1, 0, 2'b11, 0, 1, 1, 4'd1};
    tbl[2]  = '{1, 0, 0,  0, 0, 2'b00, 0, 0, 1, 4'd1};
    tbl[3]  = '{1, 0, 0,  0, 0, 2'b00, 0, 0, 0, 4'd1};
    tbl[4]  = '{1, 1, 1,  0, 0, 2'b11, 0, 0, 1, 4'd1};
    tbl[5]  = '{1, 1, 1,  0, 1, 2'b10, 1, 0, 1, 4'd2};
    tbl[6]  = '{1, 1, 1,  0, 0, 2'b00, 0, 0, 1, 4'd2};
    tbl[7]  = '{1, 1, 1,  0, 0, 2'b00, 0, 0, 0, 4'd2};
    tbl[8]  = '{1, 1, 1,  0, 0, 2'b10, 0, 0, 1, 4'd2};
    tbl[9]  = '{1, 0, 0,  1, 0, 2'b11, 0, 1, 1, 4'd3};
    tbl[10] = '{1, 0, 0,  0, 0, 2'b00, 0, 0, 1, 4'd3};
    tbl[11] = '{0, 1, 0,  0, 0, 2'b00, 0, 0, 0, 4'd3};
    tbl[12] = '{0, 1, 1,  0, 0, 2'b00, 0, 0, 0, 4'd3};
    tbl[13] = '{1, 1, 1,  0, 0, 2'b11, 0, 0, 1, 4'd3};
    tbl[14] = '{0, 0, 0,  0, 1, 2'b10, 1, 0, 1, 4'd4};
    tbl[15] = '{0, 0, 0,  0, 0, 2'b00, 0, 0, 1, 4'd4};
    tbl[16] = '{1, 0, 1,  0, 0, 2'b00, 0, 0, 0, 4'd4};
    tbl[17] = '{1, 0, 1,  0, 0, 2'b11, 0, 0, 1, 4'd4};
    tbl[18] = '{0, 0, 0,  0, 1, 2'b10, 1, 0, 1, 4'd5};
    tbl[19] = '{0, 0, 0,  0, 0, 2'b00, 0, 0, 1, 4'd5};
    tbl[20] = '{0, 0, 0,  0, 0, 2'b00, 0, 0, 0, 4'd5};

    do_reset();
    chk("rst_busy",  32'(ia.busy),     32'd0);
    chk("rst_sel_i", 32'(ia.sel_i),    32'd0);
    chk("rst_sel_o", 32'({ia.sel_o1, ia.sel_o2}), 32'd0);
    chk("rst_ack",   32'({ia.ack1, ia.ack2}),     32'd0);
    chk("rst_cnt",   32'(ia.xfer_cnt), 32'd0);
    chk("rst_state", 32'(ia.state),    32'd0);

    for (int i = 0; i < 21; i++) begin
      ia.en = tbl[i].en; ia.req1 = tbl[i].r1; ia.req2 = tbl[i].r2;
      step();
      chk($sformatf("v%0d_ack1", i),  32'(ia.ack1),     32'(tbl[i].a1));
      chk($sformatf("v%0d_ack2", i),  32'(ia.ack2),     32'(tbl[i].a2));
      chk($sformatf("v%0d_sel_i", i), 32'(ia.sel_i),    32'(tbl[i].si));
      chk($sformatf("v%0d_sel_o1", i), 32'(ia.sel_o1),  32'(tbl[i].o1));
      chk($sformatf("v%0d_sel_o2", i), 32'(ia.sel_o2),  32'(tbl[i].o2));
      chk($sformatf("v%0d_busy", i),  32'(ia.busy),     32'(tbl[i].bsy));
      chk($sformatf("v%0d_cnt", i),   32'(ia.xfer_cnt), 32'(tbl[i].cnt));
    end

    // Both requesters held from reset: grants alternate 1,2,1,2 with acks 4 cycles apart.
    do_reset();
    ia.en = 1'b1; ia.req1 = 1'b1; ia.req2 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk($sformatf("rr_c%0d_ack1", c), 32'(ia.ack1), 32'((c % 8) == 2));
      chk($sformatf("rr_c%0d_ack2", c), 32'(ia.ack2), 32'((c % 8) == 6));
    end
    ia.req1 = 1'b0; ia.req2 = 1'b0;
    chk("rr_cnt", 32'(ia.xfer_cnt), 32'd4);

    // Enable low holds off the grant; raising it grants on the next edge.
    ia.en = 1'b0; ia.req1 = 1'b1;
    busy_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ia.busy) busy_cyc++;
    end
    chk("en_off_busy", 32'(busy_cyc), 32'd0);
    chk("en_off_state", 32'(ia.state), 32'd0);
    ia.en = 1'b1;
    step();
    chk("en_on_sel_i", 32'(ia.sel_i), 32'b10);
    chk("en_on_state", 32'(ia.state), 32'b01);
    ia.req1 = 1'b0;
    step(); step(); step();
    chk("en_on_cnt", 32'(ia.xfer_cnt), 32'd5);

    // Reset in the middle of a DRV_CYC=3 drive phase.
    do_reset();
    ib.en = 1'b1; ib.req1 = 1'b1;
    step();
    ib.req1 = 1'b0;
    step();
    chk("abort_pre_sel_o2", 32'(ib.sel_o2), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_sel_o2", 32'(ib.sel_o2),   32'd0);
    chk("abort_ack1",   32'(ib.ack1),     32'd0);
    chk("abort_busy",   32'(ib.busy),     32'd0);
    chk("abort_sel_i",  32'(ib.sel_i),    32'd0);
    @(posedge clk);
    #4 rst = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (ib.ack1 || ib.ack2) acks++;
    end
    chk("abort_no_ack", 32'(acks),        32'd0);
    chk("abort_cnt",    32'(ib.xfer_cnt), 32'd0);
    chk("abort_state",  32'(ib.state),    32'd0);

    // DRV_CYC=3 port-2 transfer: act1 driven for three cycles, ack on the last.
    ib.en = 1'b1; ib.req2 = 1'b1;
    step();
    busy_cyc = 32'(ib.busy);
    chk("d3_cap_sel_i", 32'(ib.sel_i), 32'b11);
    chk("d3_cap_sel_o", 32'({ib.sel_o1, ib.sel_o2}), 32'd0);
    ib.req2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (ib.busy) busy_cyc++;
      chk($sformatf("d3_drv%0d_sel_o1", k), 32'(ib.sel_o1), 32'd1);
      chk($sformatf("d3_drv%0d_sel_o2", k), 32'(ib.sel_o2), 32'd0);
      chk($sformatf("d3_drv%0d_sel_i", k),  32'(ib.sel_i),  32'b10);
      chk($sformatf("d3_drv%0d_ack2", k),   32'(ib.ack2),   32'(k == 2));
    end
    step();
    if (ib.busy) busy_cyc++;
    chk("d3_gap_sel", 32'({ib.sel_i, ib.sel_o1, ib.sel_o2}), 32'd0);
    step();
    if (ib.busy) busy_cyc++;
    chk("d3_busy_cycles", 32'(busy_cyc), 32'd5);
    chk("d3_cnt", 32'(ib.xfer_cnt), 32'd1);
    ib.en = 1'b0;

    // Four-bit counter wraps to zero on the 16th ack.
    do_reset();
    ia.en = 1'b1; ia.req1 = 1'b1;
    acks = 0;
    for (int c = 0; c < 100 && acks < 16; c++) begin
      step();
      if (ia.ack1) begin
        acks++;
        if (acks == 15) chk("wrap_cnt15", 32'(ia.xfer_cnt), 32'd15);
        if (acks == 16) chk("wrap_cnt0",  32'(ia.xfer_cnt), 32'd0);
      end
    end
    chk("wrap_acks", 32'(acks), 32'd16);
    ia.req1 = 1'b0;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
